// File: rtl/lsu_seq.sv
// ============================================================================
//  Module   : lsu_seq
//  Purpose  : Load/store sequencer; splits byte/halfword requests into
//             per-byte cycles on an 8-bit data memory (little-endian).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_seq #(
    parameter int W = 8,
    parameter int A = 8
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           Req,
    input  logic           Write,
    input  logic           Wide,
    input  logic [A-1:0]   Addr,
    input  logic [2*W-1:0] WrData,
    output logic           Busy,
    output logic           Done,
    output logic [2*W-1:0] RdData,
    output logic           MemWriteEn,
    output logic [A-1:0]   MemAddr,
    output logic [W-1:0]   MemDataIn,
    input  logic [W-1:0]   MemDataOut
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [A-1:0] ADDR_ONE = {{(A-1){1'b0}}, 1'b1};

    state_t         state;
    logic [A-1:0]   addr_q;
    logic [2*W-1:0] wd_q;
    logic           wr_q;
    logic           wide_q;
    logic [W-1:0]   lo_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            addr_q <= '0;
            wd_q   <= '0;
            wr_q   <= 1'b0;
            wide_q <= 1'b0;
            lo_q   <= '0;
            RdData <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Req) begin
                        addr_q <= Addr;
                        wd_q   <= WrData;
                        wr_q   <= Write;
                        wide_q <= Wide;
                        state  <= LO;
                    end
                end
                LO: begin
                    if (!wr_q) begin
                        lo_q <= MemDataOut;
                    end
                    if (wide_q) begin
                        state <= HI;
                    end else begin
                        state <= DONE;
                        // Narrow load result is final at this edge, zero-extended.
                        if (!wr_q) begin
                            RdData <= {{W{1'b0}}, MemDataOut};
                        end
                    end
                end
                HI: begin
                    if (!wr_q) begin
                        RdData <= {MemDataOut, lo_q};
                    end
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory strobes decode only from registered state, so reset kills
    // MemWriteEn at once and request inputs never reach the memory directly.
    always_comb begin
        Busy       = (state != IDLE);
        Done       = (state == DONE);
        MemWriteEn = 1'b0;
        MemAddr    = '0;
        MemDataIn  = '0;
        case (state)
            LO: begin
                MemAddr = addr_q;
                if (wr_q) begin
                    MemWriteEn = 1'b1;
                    MemDataIn  = wd_q[W-1:0];
                end
            end
            HI: begin
                MemAddr = addr_q + ADDR_ONE;
                if (wr_q) begin
                    MemWriteEn = 1'b1;
                    MemDataIn  = wd_q[2*W-1:W];
                end
            end
            default: begin
                MemWriteEn = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu_seq.sv
// ============================================================================
//  Module   : tb_lsu_seq
//  Purpose  : Directed scoreboard bench for lsu_seq with a byte memory model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lsu_seq;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Req = 1'b0;
    logic        Write = 1'b0;
    logic        Wide = 1'b0;
    logic [7:0]  Addr = 8'h00;
    logic [15:0] WrData = 16'h0000;
    logic        Busy;
    logic        Done;
    logic [15:0] RdData;
    logic        MemWriteEn;
    logic [7:0]  MemAddr;
    logic [7:0]  MemDataIn;
    logic [7:0]  MemDataOut;

    lsu_seq #(.W(8), .A(8)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Req        (Req),
        .Write      (Write),
        .Wide       (Wide),
        .Addr       (Addr),
        .WrData     (WrData),
        .Busy       (Busy),
        .Done       (Done),
        .RdData     (RdData),
        .MemWriteEn (MemWriteEn),
        .MemAddr    (MemAddr),
        .MemDataIn  (MemDataIn),
        .MemDataOut (MemDataOut)
    );

    always #5 Clk = ~Clk;

    logic [7:0] mem [256];
    int         nwr = 0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    assign MemDataOut = mem[MemAddr];

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (MemWriteEn) begin
            mem[MemAddr] <= MemDataIn;
            nwr++;
        end
    end

    typedef struct {
        logic [15:0] rd;
        int          done_cyc;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every Done pulse must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        if (Done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("rddata", {16'h0, RdData}, {16'h0, e.rd});
                chk("latency", cyc, e.done_cyc);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (Busy && n < 12) begin
            @(negedge Clk);
            n++;
        end
        chk("idle_timeout", {31'h0, Busy}, 32'd0);
    endtask

    task automatic run(input logic wr, input logic wd, input logic [7:0] a,
                       input logic [15:0] d, input logic [15:0] exp_rd);
        @(negedge Clk);
        Req = 1'b1; Write = wr; Wide = wd; Addr = a; WrData = d;
        sbq.push_back('{exp_rd, cyc + (wd ? 3 : 2)});
        @(negedge Clk);
        // Scramble inputs after sampling; the in-flight op must not notice.
        Req = 1'b0; Write = ~wr; Wide = ~wd; Addr = 8'hC3; WrData = 16'h5A5A;
        wait_idle();
    endtask

    int w0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h30] = 8'h11;
        mem[8'h31] = 8'h22;
        mem[8'h20] = 8'h5A;
        mem[8'h41] = 8'h77;

        #3;
        chk("rst_busy",   {31'h0, Busy}, 32'd0);
        chk("rst_done",   {31'h0, Done}, 32'd0);
        chk("rst_we",     {31'h0, MemWriteEn}, 32'd0);
        chk("rst_addr",   {24'h0, MemAddr}, 32'd0);
        chk("rst_din",    {24'h0, MemDataIn}, 32'd0);
        chk("rst_rddata", {16'h0, RdData}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;

        // Narrow store then load.
        w0 = nwr;
        run(1'b1, 1'b0, 8'h10, 16'hBEEF, 16'h0000);
        chk("nst_mem10", {24'h0, mem[8'h10]}, 32'hEF);
        chk("nst_mem11", {24'h0, mem[8'h11]}, 32'h00);
        chk("nst_writes", nwr - w0, 32'd1);
        run(1'b0, 1'b0, 8'h10, 16'h0000, 16'h00EF);

        // Wide store/load wrapping past 0xFF.
        w0 = nwr;
        run(1'b1, 1'b1, 8'hFF, 16'h1234, 16'h00EF);
        chk("wst_memFF", {24'h0, mem[8'hFF]}, 32'h34);
        chk("wst_mem00", {24'h0, mem[8'h00]}, 32'h12);
        chk("wst_writes", nwr - w0, 32'd2);
        run(1'b0, 1'b1, 8'hFF, 16'h0000, 16'h1234);

        // Request held during a wide load is ignored until after Done.
        @(negedge Clk);
        Req = 1'b1; Write = 1'b0; Wide = 1'b1; Addr = 8'h30;
        sbq.push_back('{16'h2211, cyc + 3});
        @(negedge Clk);
        Addr = 8'h20; Wide = 1'b0;
        chk("ign_lo_addr", {24'h0, MemAddr}, 32'h30);
        @(negedge Clk);
        chk("ign_hi_addr", {24'h0, MemAddr}, 32'h31);
        sbq.push_back('{16'h005A, cyc + 4});
        @(negedge Clk);
        chk("ign_done_addr", {24'h0, MemAddr}, 32'h00);
        @(negedge Clk);
        chk("ign_idle", {31'h0, Busy}, 32'd0);
        @(negedge Clk);
        chk("ign_accept_addr", {24'h0, MemAddr}, 32'h20);
        Req = 1'b0;
        wait_idle();

        // Reset pulsed during the HI cycle of a wide store.
        w0 = nwr;
        @(negedge Clk);
        Req = 1'b1; Write = 1'b1; Wide = 1'b1; Addr = 8'h40; WrData = 16'hAA55;
        @(negedge Clk);
        Req = 1'b0;
        @(posedge Clk);
        #2;
        chk("mid_we_before", {31'h0, MemWriteEn}, 32'd1);
        Reset = 1'b1;
        #1;
        chk("mid_busy",   {31'h0, Busy}, 32'd0);
        chk("mid_done",   {31'h0, Done}, 32'd0);
        chk("mid_we",     {31'h0, MemWriteEn}, 32'd0);
        chk("mid_addr",   {24'h0, MemAddr}, 32'd0);
        chk("mid_rddata", {16'h0, RdData}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (4) @(negedge Clk);
        chk("mid_mem40", {24'h0, mem[8'h40]}, 32'h55);
        chk("mid_mem41", {24'h0, mem[8'h41]}, 32'h77);
        chk("mid_writes", nwr - w0, 32'd1);

        // Stores leave RdData untouched.
        run(1'b0, 1'b1, 8'h40, 16'h0000, 16'h7755);
        run(1'b1, 1'b0, 8'h50, 16'h0099, 16'h7755);
        chk("st_mem50", {24'h0, mem[8'h50]}, 32'h99);
        @(negedge Clk);
        chk("st_rddata_hold", {16'h0, RdData}, 32'h7755);

        repeat (2) @(negedge Clk);
        chk("sb_drained", sbq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
